// File: rtl/tape_tx_scheduler.sv
// tape_tx_scheduler: two-requester block framer (SYNC, ID, payload[, XOR checksum]) feeding one output register.
// Optional feature macro: TAPE_TX_CHECKSUM_EN appends a checksum byte and enables the CSUM state.
`default_nettype none

module tape_tx_scheduler #(
  parameter int unsigned BLOCK_LEN = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk_ntsc,
  input  logic        rst,
  input  logic        src0_valid,
  input  logic [7:0]  src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [7:0]  src1_data,
  output logic        src1_ready,
  output logic        data_out_ready,
  output logic [7:0]  data_out,
  input  logic        output_ready,
  output logic        grant,
  output logic        busy,
  output logic [15:0] block_count
);

  localparam logic [7:0] c_LEN = 8'(BLOCK_LEN);

`ifdef TAPE_TX_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_PAYLOAD, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ID, S_PAYLOAD} state_t;
`endif

  state_t      r_state, w_state_n;
  logic        r_dor, w_dor_n;
  logic [7:0]  r_dout, w_dout_n;
  logic        r_grant, w_grant_n;
  logic        r_last_grant, w_last_grant_n;
  logic [7:0]  r_count, w_count_n;
  logic [15:0] r_block_count, w_block_count_n;
`ifdef TAPE_TX_CHECKSUM_EN
  logic [7:0]  r_csum, w_csum_n;
`endif

  logic       w_load;
  logic       w_payload_st;
  logic       w_grant_ready;
  logic       w_gnt_valid;
  logic [7:0] w_gnt_data;
  logic       w_take;
  logic       w_arb;

  assign w_load        = !r_dor || output_ready;
  assign w_payload_st  = (r_state == S_ID) || (r_state == S_PAYLOAD);
  assign w_grant_ready = w_load && w_payload_st && (r_count < c_LEN);
  assign w_gnt_valid   = r_grant ? src1_valid : src0_valid;
  assign w_gnt_data    = r_grant ? src1_data : src0_data;
  assign w_take        = w_grant_ready && w_gnt_valid;
  // Tie alternates against the previous winner; a lone request simply wins.
  assign w_arb         = (src0_valid && src1_valid) ? !r_last_grant : src1_valid;

  always_comb begin
    w_state_n       = r_state;
    w_dor_n         = r_dor;
    w_dout_n        = r_dout;
    w_grant_n       = r_grant;
    w_last_grant_n  = r_last_grant;
    w_count_n       = r_count;
`ifdef TAPE_TX_CHECKSUM_EN
    w_csum_n        = r_csum;
`endif
    w_block_count_n = r_block_count;

    // In IDLE a full register can only hold the previous block's final byte.
    if (r_state == S_IDLE && r_dor && output_ready)
      w_block_count_n = r_block_count + 16'd1;

    case (r_state)
      S_IDLE: begin
        if (!r_dor && (src0_valid || src1_valid)) begin
          w_state_n      = S_SYNC;
          w_dor_n        = 1'b1;
          w_dout_n       = SYNC_BYTE;
          w_grant_n      = w_arb;
          w_last_grant_n = w_arb;
          w_count_n      = 8'd0;
`ifdef TAPE_TX_CHECKSUM_EN
          w_csum_n       = 8'd0;
`endif
        end else if (w_load) begin
          w_dor_n = 1'b0;
        end
      end
      S_SYNC: begin
        if (w_load) begin
          w_state_n = S_ID;
          w_dor_n   = 1'b1;
          w_dout_n  = {7'b0, r_grant};
        end
      end
      S_ID, S_PAYLOAD: begin
        if (w_take) begin
          w_dor_n   = 1'b1;
          w_dout_n  = w_gnt_data;
          w_count_n = r_count + 8'd1;
`ifdef TAPE_TX_CHECKSUM_EN
          w_csum_n  = r_csum ^ w_gnt_data;
          w_state_n = (r_count + 8'd1 == c_LEN) ? S_CSUM : S_PAYLOAD;
`else
          w_state_n = (r_count + 8'd1 == c_LEN) ? S_IDLE : S_PAYLOAD;
`endif
        end else if (w_load) begin
          w_dor_n = 1'b0;
        end
      end
`ifdef TAPE_TX_CHECKSUM_EN
      S_CSUM: begin
        if (w_load) begin
          w_state_n = S_IDLE;
          w_dor_n   = 1'b1;
          w_dout_n  = r_csum;
        end
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ntsc or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dor         <= 1'b0;
      r_dout        <= 8'h00;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_count       <= 8'd0;
`ifdef TAPE_TX_CHECKSUM_EN
      r_csum        <= 8'd0;
`endif
      r_block_count <= 16'd0;
    end else begin
      r_state       <= w_state_n;
      r_dor         <= w_dor_n;
      r_dout        <= w_dout_n;
      r_grant       <= w_grant_n;
      r_last_grant  <= w_last_grant_n;
      r_count       <= w_count_n;
`ifdef TAPE_TX_CHECKSUM_EN
      r_csum        <= w_csum_n;
`endif
      r_block_count <= w_block_count_n;
    end
  end

  assign src0_ready     = w_grant_ready && !r_grant;
  assign src1_ready     = w_grant_ready && r_grant;
  assign data_out_ready = r_dor;
  assign data_out       = r_dout;
  assign grant          = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign block_count    = r_block_count;

endmodule

`default_nettype wire

// File: tb/tb_tape_tx_scheduler.sv
// tb_tape_tx_scheduler: directed self-checking bench for tape_tx_scheduler with BLOCK_LEN=4.
// Expected streams include the checksum byte only when TAPE_TX_CHECKSUM_EN is defined.
`default_nettype none

module tb_tape_tx_scheduler;

`ifdef TAPE_TX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int BL = 6 + (CS ? 1 : 0);

  logic        clk_ntsc = 1'b0;
  logic        rst = 1'b1;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic [7:0]  src0_data = 8'h00, src1_data = 8'h00;
  logic        src0_ready, src1_ready;
  logic        data_out_ready;
  logic [7:0]  data_out;
  logic        output_ready = 1'b1;
  logic        grant, busy;
  logic [15:0] block_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$], q1[$];
  logic [8:0] trace[$], exp_q[$];
  logic [7:0] acc[$], exp_a[$];
  bit         en0 = 1'b0, en1 = 1'b0;
  logic       s_dor, s_r0, s_r1, s_busy, s_grant;
  logic [7:0] s_dout;

  tape_tx_scheduler #(.BLOCK_LEN(4), .SYNC_BYTE(8'hA5)) dut (
    .clk_ntsc(clk_ntsc), .rst(rst),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .data_out_ready(data_out_ready), .data_out(data_out), .output_ready(output_ready),
    .grant(grant), .busy(busy), .block_count(block_count)
  );

  always #5 clk_ntsc = ~clk_ntsc;

  function automatic void drive();
    src0_valid = en0 && (q0.size() > 0);
    src0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    src1_valid = en1 && (q1.size() > 0);
    src1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  endfunction

  function automatic void add_block(input logic [7:0] id, input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cs);
    exp_q.push_back(9'h0A5); exp_q.push_back({1'b0, id});
    exp_q.push_back({1'b0, b0}); exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b0, b2}); exp_q.push_back({1'b0, b3});
    if (CS) exp_q.push_back({1'b0, cs});
  endfunction

  // One clock: sample mid-cycle, then pop consumed source bytes just after the edge.
  task automatic step();
    logic h0, h1;
    @(negedge clk_ntsc);
    s_dor = data_out_ready; s_dout = data_out; s_r0 = src0_ready; s_r1 = src1_ready;
    s_busy = busy; s_grant = grant;
    h0 = src0_valid && src0_ready;
    h1 = src1_valid && src1_ready;
    trace.push_back(s_dor ? {1'b0, s_dout} : 9'h100);
    if (s_dor && output_ready) acc.push_back(s_dout);
    @(posedge clk_ntsc);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    en0 = 1'b0; en1 = 1'b0;
    output_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk_ntsc);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    rst = 1'b1;
    q0 = {8'h01}; en0 = 1'b1; drive();
    @(posedge clk_ntsc); #1;
    obs = {data_out_ready, data_out, src0_ready, src1_ready, grant, busy, block_count};
    checks++;
    if (obs !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, 29'd0);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    trace.delete(); exp_q.delete();
    q0 = {8'h01, 8'h02, 8'h03, 8'h04}; en0 = 1'b1; drive();
    repeat (9) step();
    exp_q.push_back(9'h100);
    add_block(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    while (exp_q.size() < 9) exp_q.push_back(9'h100);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (trace[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL stream_cycle%0d got %h exp %h", k, trace[k], exp_q[k]);
      end
    end
    checks++;
    if (block_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_count got bc=%0d busy=%b exp bc=1 busy=0", block_count, busy);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    trace.delete(); exp_q.delete();
    q0 = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    q1 = {8'h03, 8'h05, 8'h06, 8'h09};
    en0 = 1'b1; en1 = 1'b1; drive();
    for (int i = 0; i < 1 + 3 * (BL + 1); i++) begin
      step();
      checks++;
      if ((s_grant ? s_r0 : s_r1) !== 1'b0) begin
        errors++;
        $display("FAIL arb_nongrant_ready cycle%0d got r0=%b r1=%b grant=%b exp 0 on non-granted", i, s_r0, s_r1, s_grant);
      end
    end
    exp_q.push_back(9'h100);
    add_block(8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F); exp_q.push_back(9'h100);
    add_block(8'h01, 8'h03, 8'h05, 8'h06, 8'h09, 8'h09); exp_q.push_back(9'h100);
    add_block(8'h00, 8'h10, 8'h20, 8'h40, 8'h80, 8'hF0); exp_q.push_back(9'h100);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (trace[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL arb_cycle%0d got %h exp %h", k, trace[k], exp_q[k]);
      end
    end
    checks++;
    if (block_count !== 16'd3) begin
      errors++;
      $display("FAIL arb_count got %0d exp 3", block_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    acc.delete(); trace.delete();
    q0 = {8'h01, 8'h02, 8'h03, 8'h04}; en0 = 1'b1; drive();
    for (int i = 0; i < 14; i++) begin
      output_ready = !(i >= 4 && i <= 6);
      step();
      if (i >= 4 && i <= 6) begin
        checks++;
        if ({s_dor, s_dout, s_r0} !== {1'b1, 8'h02, 1'b0}) begin
          errors++;
          $display("FAIL bp_hold cycle%0d got dor=%b data=%h r0=%b exp dor=1 data=02 r0=0", i, s_dor, s_dout, s_r0);
        end
      end
    end
    output_ready = 1'b1;
    exp_a = {8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CS) exp_a.push_back(8'h04);
    checks++;
    if (acc.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL bp_len got %0d exp %0d", acc.size(), exp_a.size());
    end else begin
      for (int k = 0; k < exp_a.size(); k++) begin
        checks++;
        if (acc[k] !== exp_a[k]) begin
          errors++;
          $display("FAIL bp_byte%0d got %h exp %h", k, acc[k], exp_a[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    acc.delete(); trace.delete();
    q1 = {8'h11, 8'h22, 8'h44, 8'h88}; en1 = 1'b1; drive();
    for (int i = 0; i < 14; i++) begin
      en1 = !(i >= 4 && i <= 8);
      drive();
      step();
      if (i >= 5 && i <= 8) begin
        checks++;
        if ({s_dor, s_busy, s_grant} !== 3'b011) begin
          errors++;
          $display("FAIL stall_wait cycle%0d got dor=%b busy=%b grant=%b exp 0 1 1", i, s_dor, s_busy, s_grant);
        end
      end
    end
    en1 = 1'b0;
    exp_a = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h44, 8'h88};
    if (CS) exp_a.push_back(8'hFF);
    checks++;
    if (acc.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL stall_len got %0d exp %0d", acc.size(), exp_a.size());
    end else begin
      for (int k = 0; k < exp_a.size(); k++) begin
        checks++;
        if (acc[k] !== exp_a[k]) begin
          errors++;
          $display("FAIL stall_byte%0d got %h exp %h", k, acc[k], exp_a[k]);
        end
      end
    end
    checks++;
    if (block_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_count got %0d exp 1", block_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [28:0] obs;
    trace.delete();
    q1 = {8'h31, 8'h32, 8'h33, 8'h34}; en1 = 1'b1; drive();
    repeat (3) step();
    checks++;
    if ({busy, grant, data_out_ready, data_out, block_count} !== {3'b111, 8'h31, 16'd1}) begin
      errors++;
      $display("FAIL rstmid_pre got busy=%b grant=%b dor=%b data=%h bc=%0d exp 1 1 1 31 1",
               busy, grant, data_out_ready, data_out, block_count);
    end
    rst = 1'b1;
    #1;
    obs = {data_out_ready, data_out, src0_ready, src1_ready, grant, busy, block_count};
    checks++;
    if (obs !== 29'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h exp %h", obs, 29'd0);
    end
    q1.delete(); en1 = 1'b0; drive();
    @(posedge clk_ntsc); #1;
    rst = 1'b0;
    trace.delete();
    q0 = {8'h01, 8'h02, 8'h03, 8'h04}; en0 = 1'b1; drive();
    repeat (3) step();
    exp_q = {9'h100, 9'h0A5, 9'h000};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (trace[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rstmid_restart%0d got %h exp %h", k, trace[k], exp_q[k]);
      end
    end
    checks++;
    if (block_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_count got %0d exp 0", block_count);
    end
    repeat (7) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_arbitration();
    test_backpressure();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tape_tx_scheduler.md
TAPE_TX_SCHEDULER -- requirements
Module: tape_tx_scheduler

Interface
REQ-001 Parameter BLOCK_LEN, default 64: payload bytes per block; legal range 1..255.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every block.
REQ-003 clk_ntsc  input  1  pixel clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 src0_valid  input  1  requester 0 (Ethernet RX path) has a byte.
REQ-006 src0_data  input  8  requester 0 byte.
REQ-007 src0_ready  output  1  requester 0 byte consumed this cycle when src0_valid is also high.
REQ-008 src1_valid / src1_data / src1_ready  in/in/out  1/8/1  requester 1 (pattern source); same rules as requester 0.
REQ-009 data_out_ready  output  1  byte valid toward video_out.
REQ-010 data_out  output  8  byte toward video_out.
REQ-011 output_ready  input  1  video_out accepts data_out this cycle.
REQ-012 grant  output  1  index of the requester owning the current block.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 block_count  output  16  completed blocks; wraps 65535->0.

Function
REQ-015 data_out/data_out_ready SHALL form a single output register; an accept = data_out_ready && output_ready.
REQ-016 load = !data_out_ready || output_ready; a new byte enters the register only on a load edge.
REQ-017 data_out SHALL hold stable while data_out_ready is high and output_ready is low.
REQ-018 States: IDLE, SYNC, ID, PAYLOAD, CSUM.
REQ-019 IDLE: when data_out_ready is low and either srcN_valid is high, SHALL latch grant, load SYNC_BYTE, and go to SYNC.
REQ-020 Arbitration: one valid wins; both valid -> grant = !last_grant; last_grant updates on every IDLE->SYNC transition.
REQ-021 SYNC: on load, SHALL load {7'b0, grant} and go to ID.
REQ-022 ID/PAYLOAD: srcG_ready = load while payload count < BLOCK_LEN; each handshake SHALL load srcG_data, increment the count, and XOR the byte into the checksum.
REQ-023 ID/PAYLOAD: a load edge with srcG_valid low SHALL clear data_out_ready (the register empties) without a state change; the scheduler waits.
REQ-024 The non-granted requester's ready SHALL be 0 at all times.
REQ-025 After the BLOCK_LEN-th payload byte is loaded, the state SHALL become CSUM (CHECKSUM_EN) or IDLE (no CHECKSUM_EN).
REQ-026 CSUM: on load, SHALL load the checksum byte and go to IDLE.
REQ-027 Blocks SHALL be separated by at least one cycle with data_out_ready low.
REQ-028 block_count SHALL increment on the accept of a block's final byte.
REQ-029 Latency: first SYNC_BYTE valid one cycle after the IDLE edge that sees a request; zero-stall block duration SHALL be BLOCK_LEN+3 cycles (CHECKSUM_EN) or BLOCK_LEN+2 cycles (without).
REQ-030 Requester valid dropping after a block starts SHALL NOT abort the block.

Reset
REQ-031 With rst high: state=IDLE, data_out_ready=0, data_out=8'h00, src0_ready=src1_ready=0, grant=0, busy=0, block_count=0, payload count=0, checksum=0, last_grant=1 (requester 0 wins the first tie).
REQ-032 Reset asserted mid-block SHALL discard the partial block immediately; no byte SHALL be emitted until a new SYNC_BYTE.

Configuration
REQ-033 Macro TAPE_TX_CHECKSUM_EN defined: each block SHALL be SYNC, ID, payload, XOR checksum (BLOCK_LEN+3 bytes).
REQ-034 TAPE_TX_CHECKSUM_EN undefined: CSUM state and checksum register SHALL be absent; each block SHALL be BLOCK_LEN+2 bytes.

Verification (BLOCK_LEN=4, TAPE_TX_CHECKSUM_EN defined unless stated)
REQ-035 src0 streams 01,02,03,04, output_ready=1 -> out A5,00,01,02,03,04,04 on consecutive cycles; block_count=1.
REQ-036 src0 and src1 valid together from reset -> block from src0 (ID 00), then src1 (ID 01), then src0; a gap cycle between blocks.
REQ-037 output_ready low 3 cycles while data_out=02 -> data_out stays 02, src0_ready=0, no byte lost or duplicated.
REQ-038 src1 valid drops after 2 payload bytes for 5 cycles -> data_out_ready low, state PAYLOAD, block resumes and completes with correct checksum.
REQ-039 rst pulsed after ID byte -> all outputs at reset values next edge; next block starts with A5 and block_count=0.
REQ-040 TAPE_TX_CHECKSUM_EN undefined, src0 streams 01..04 -> out A5,00,01,02,03,04 only; block_count=1.
